// File: rtl/mor1kx_decode_execute_cappuccino.sv
// mor1kx_decode_execute_cappuccino
//   Decode->execute pipeline register of the cappuccino pipeline. Latches the
//   decoded operation, register addresses, immediate, PC and decode-time
//   exceptions into the execute stage. Detects load-use and mfspr-use hazards
//   against the instruction currently in execute and inserts a nop bubble.
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   padv_execute_i                execute stage advances this cycle
//   pipeline_flush_i              kill the instruction held in execute
//   decode_valid_i                decode holds a real instruction
//   pc_decode_i / pc_execute_o    PC in decode / execute
//   decode_* / execute_*          operand addresses, rf writeback, immediate,
//                                 op decode bits and exception bits
//   execute_bubble_o              execute holds an inserted nop
//   decode_stall_o                decode must not advance (combinational)
module mor1kx_decode_execute_cappuccino #(
  parameter int unsigned OPTION_OPERAND_WIDTH = 32,
  parameter logic [OPTION_OPERAND_WIDTH-1:0] OPTION_RESET_PC =
    {{(OPTION_OPERAND_WIDTH-13){1'b0}}, 5'h01, 8'd0},
  parameter int unsigned OPTION_RF_ADDR_WIDTH = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            padv_execute_i,
  input  logic                            pipeline_flush_i,
  input  logic                            decode_valid_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] pc_decode_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] decode_rfa_adr_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] decode_rfb_adr_i,
  input  logic                            decode_rfa_used_i,
  input  logic                            decode_rfb_used_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] decode_rfd_adr_i,
  input  logic                            decode_rf_wb_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] decode_imm_i,
  input  logic                            decode_op_lsu_load_i,
  input  logic                            decode_op_lsu_store_i,
  input  logic                            decode_op_lsu_atomic_i,
  input  logic                            decode_op_mfspr_i,
  input  logic                            decode_op_mtspr_i,
  input  logic                            decode_op_jal_i,
  input  logic                            decode_op_jr_i,
  input  logic                            decode_op_rfe_i,
  input  logic                            decode_op_mul_i,
  input  logic                            decode_except_ibus_err_i,
  input  logic                            decode_except_itlb_miss_i,
  input  logic                            decode_except_ipagefault_i,
  input  logic                            decode_except_ibus_align_i,
  input  logic                            decode_except_illegal_i,
  input  logic                            decode_except_syscall_i,
  input  logic                            decode_except_trap_i,
  output logic [OPTION_RF_ADDR_WIDTH-1:0] execute_rfa_adr_o,
  output logic [OPTION_RF_ADDR_WIDTH-1:0] execute_rfb_adr_o,
  output logic [OPTION_RF_ADDR_WIDTH-1:0] execute_rfd_adr_o,
  output logic                            execute_rf_wb_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] execute_imm_o,
  output logic                            execute_op_lsu_load_o,
  output logic                            execute_op_lsu_store_o,
  output logic                            execute_op_lsu_atomic_o,
  output logic                            execute_op_mfspr_o,
  output logic                            execute_op_mtspr_o,
  output logic                            execute_op_jal_o,
  output logic                            execute_op_jr_o,
  output logic                            execute_op_rfe_o,
  output logic                            execute_op_mul_o,
  output logic                            execute_except_ibus_err_o,
  output logic                            execute_except_itlb_miss_o,
  output logic                            execute_except_ipagefault_o,
  output logic                            execute_except_ibus_align_o,
  output logic                            execute_except_illegal_o,
  output logic                            execute_except_syscall_o,
  output logic                            execute_except_trap_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] pc_execute_o,
  output logic                            execute_bubble_o,
  output logic                            decode_stall_o
);

  localparam int unsigned OW = OPTION_OPERAND_WIDTH;
  localparam int unsigned RW = OPTION_RF_ADDR_WIDTH;

  // Op and exception bits travel as packed vectors so that clearing them on
  // flush/bubble is a single assignment each.
  logic [8:0]    decode_ops;
  logic [6:0]    decode_exc;
  logic [8:0]    ops_q, ops_d;
  logic [6:0]    exc_q, exc_d;
  logic          rf_wb_q, rf_wb_d;
  logic          bubble_q, bubble_d;
  logic [OW-1:0] pc_q, pc_d;
  logic [OW-1:0] imm_q, imm_d;
  logic [RW-1:0] rfa_q, rfa_d;
  logic [RW-1:0] rfb_q, rfb_d;
  logic [RW-1:0] rfd_q, rfd_d;
  logic          hazard;

  assign decode_ops = {decode_op_mul_i, decode_op_rfe_i, decode_op_jr_i,
                       decode_op_jal_i, decode_op_mtspr_i, decode_op_mfspr_i,
                       decode_op_lsu_atomic_i, decode_op_lsu_store_i,
                       decode_op_lsu_load_i};
  assign decode_exc = {decode_except_trap_i, decode_except_syscall_i,
                       decode_except_illegal_i, decode_except_ibus_align_i,
                       decode_except_ipagefault_i, decode_except_itlb_miss_i,
                       decode_except_ibus_err_i};

  // Load and mfspr results are not available for forwarding in the next
  // cycle, so a dependent reader must wait one bubble. r0 is constant and
  // never creates a dependency.
  assign hazard = (ops_q[0] | ops_q[3]) & rf_wb_q & (rfd_q != '0) &
                  ((decode_rfa_used_i & (decode_rfa_adr_i == rfd_q)) |
                   (decode_rfb_used_i & (decode_rfb_adr_i == rfd_q)));

  assign decode_stall_o = hazard & decode_valid_i;

  always_comb begin
    ops_d    = ops_q;
    exc_d    = exc_q;
    rf_wb_d  = rf_wb_q;
    bubble_d = bubble_q;
    pc_d     = pc_q;
    imm_d    = imm_q;
    rfa_d    = rfa_q;
    rfb_d    = rfb_q;
    rfd_d    = rfd_q;
    if (pipeline_flush_i) begin
      ops_d    = '0;
      exc_d    = '0;
      rf_wb_d  = 1'b0;
      bubble_d = 1'b1;
    end else if (padv_execute_i) begin
      // Address/immediate fields load even for a bubble; rf_wb=0 makes them inert.
      imm_d = decode_imm_i;
      rfa_d = decode_rfa_adr_i;
      rfb_d = decode_rfb_adr_i;
      rfd_d = decode_rfd_adr_i;
      if (decode_valid_i && !hazard) begin
        ops_d    = decode_ops;
        exc_d    = decode_exc;
        rf_wb_d  = decode_rf_wb_i;
        bubble_d = 1'b0;
        pc_d     = pc_decode_i;
      end else begin
        ops_d    = '0;
        exc_d    = '0;
        rf_wb_d  = 1'b0;
        bubble_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ops_q    <= '0;
      exc_q    <= '0;
      rf_wb_q  <= 1'b0;
      bubble_q <= 1'b1;
      pc_q     <= OPTION_RESET_PC;
      imm_q    <= '0;
      rfa_q    <= '0;
      rfb_q    <= '0;
      rfd_q    <= '0;
    end else begin
      ops_q    <= ops_d;
      exc_q    <= exc_d;
      rf_wb_q  <= rf_wb_d;
      bubble_q <= bubble_d;
      pc_q     <= pc_d;
      imm_q    <= imm_d;
      rfa_q    <= rfa_d;
      rfb_q    <= rfb_d;
      rfd_q    <= rfd_d;
    end
  end

  assign execute_rfa_adr_o           = rfa_q;
  assign execute_rfb_adr_o           = rfb_q;
  assign execute_rfd_adr_o           = rfd_q;
  assign execute_rf_wb_o             = rf_wb_q;
  assign execute_imm_o               = imm_q;
  assign pc_execute_o                = pc_q;
  assign execute_bubble_o            = bubble_q;
  assign execute_op_lsu_load_o       = ops_q[0];
  assign execute_op_lsu_store_o      = ops_q[1];
  assign execute_op_lsu_atomic_o     = ops_q[2];
  assign execute_op_mfspr_o          = ops_q[3];
  assign execute_op_mtspr_o          = ops_q[4];
  assign execute_op_jal_o            = ops_q[5];
  assign execute_op_jr_o             = ops_q[6];
  assign execute_op_rfe_o            = ops_q[7];
  assign execute_op_mul_o            = ops_q[8];
  assign execute_except_ibus_err_o   = exc_q[0];
  assign execute_except_itlb_miss_o  = exc_q[1];
  assign execute_except_ipagefault_o = exc_q[2];
  assign execute_except_ibus_align_o = exc_q[3];
  assign execute_except_illegal_o    = exc_q[4];
  assign execute_except_syscall_o    = exc_q[5];
  assign execute_except_trap_o       = exc_q[6];

endmodule
